// File: rtl/draw_player_if.sv
// vga_pkg: screen constants shared by the video pipeline.
// vga_if: one stage's timing plus pixel colour.
`default_nettype none

package vga_pkg;
    localparam int          HOR_PIXELS = 1024;
    localparam int          VER_PIXELS = 768;
    localparam logic [11:0] BLUE       = 12'h00F;
endpackage

interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_player.sv
// draw_player: overlays a square sprite on the video stream and moves it
// once per frame, stopping at blue walls and at the screen edges.
`default_nettype none

module draw_player
    import vga_pkg::*;
#(
    parameter int unsigned SIZE         = 16,
    parameter int unsigned STEP         = 2,
    parameter int unsigned START_X      = 504,
    parameter int unsigned START_Y      = 376,
    parameter logic [11:0] PLAYER_COLOR = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [3:0]  dir_req,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic        moving
);

    typedef enum logic {IDLE, MOVE} state_t;
    typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    // Comparisons run at 12 bits so strip bounds never wrap.
    localparam logic [11:0] SZ     = 12'(SIZE);
    localparam logic [11:0] ST     = 12'(STEP);
    localparam logic [11:0] HP     = 12'(HOR_PIXELS);
    localparam logic [11:0] VP     = 12'(VER_PIXELS);
    localparam logic [10:0] STEP11 = 11'(STEP);

    state_t     state;
    dir_t       cur_dir, pending_dir, req_dir, go_dir;
    logic       vblnk_d, tick;
    logic       blk_u, blk_d, blk_l, blk_r;
    logic       bl_u, bl_d, bl_l, bl_r;
    logic       hit_u, hit_d, hit_l, hit_r;
    logic       in_cols, in_rows, active, wall, pend_ok, cur_ok;
    logic [11:0] x12, y12, h12, v12;
    logic [10:0] next_x, next_y;

    assign x12     = {1'b0, player_x};
    assign y12     = {1'b0, player_y};
    assign h12     = {1'b0, vga_in.hcount};
    assign v12     = {1'b0, vga_in.vcount};
    assign tick    = vga_in.vblnk & ~vblnk_d;
    assign active  = ~vga_in.hblnk & ~vga_in.vblnk;
    assign wall    = active && (vga_in.rgb == BLUE);
    assign in_cols = (h12 >= x12) && (h12 < x12 + SZ);
    assign in_rows = (v12 >= y12) && (v12 < y12 + SZ);

    assign hit_u = wall && in_cols && (v12 + ST >= y12) && (v12 < y12);
    assign hit_d = wall && in_cols && (v12 >= y12 + SZ) && (v12 < y12 + SZ + ST);
    assign hit_l = wall && in_rows && (h12 + ST >= x12) && (h12 < x12);
    assign hit_r = wall && in_rows && (h12 >= x12 + SZ) && (h12 < x12 + SZ + ST);

    assign bl_u = blk_u || (y12 < ST);
    assign bl_l = blk_l || (x12 < ST);
    assign bl_d = blk_d || (y12 + SZ + ST > VP);
    assign bl_r = blk_r || (x12 + SZ + ST > HP);

    assign moving = (state == MOVE);

    always_comb begin
        req_dir = D_NONE;
        if      (dir_req[3]) req_dir = D_UP;
        else if (dir_req[2]) req_dir = D_DOWN;
        else if (dir_req[1]) req_dir = D_LEFT;
        else if (dir_req[0]) req_dir = D_RIGHT;
    end

    always_comb begin
        pend_ok = 1'b0;
        cur_ok  = 1'b0;
        case (pending_dir)
            D_UP:    pend_ok = ~bl_u;
            D_DOWN:  pend_ok = ~bl_d;
            D_LEFT:  pend_ok = ~bl_l;
            D_RIGHT: pend_ok = ~bl_r;
            default: pend_ok = 1'b0;
        endcase
        case (cur_dir)
            D_UP:    cur_ok = ~bl_u;
            D_DOWN:  cur_ok = ~bl_d;
            D_LEFT:  cur_ok = ~bl_l;
            D_RIGHT: cur_ok = ~bl_r;
            default: cur_ok = 1'b0;
        endcase
        go_dir = D_NONE;
        if (pend_ok)     go_dir = pending_dir;
        else if (cur_ok) go_dir = cur_dir;
        next_x = player_x;
        next_y = player_y;
        case (go_dir)
            D_UP:    next_y = player_y - STEP11;
            D_DOWN:  next_y = player_y + STEP11;
            D_LEFT:  next_x = player_x - STEP11;
            D_RIGHT: next_x = player_x + STEP11;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
            player_x       <= 11'(START_X);
            player_y       <= 11'(START_Y);
            state          <= IDLE;
            cur_dir        <= D_NONE;
            pending_dir    <= D_NONE;
            {blk_u, blk_d, blk_l, blk_r} <= 4'b0;
            vblnk_d        <= 1'b0;
        end else begin
            vga_out.vcount <= vga_in.vcount;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.hcount <= vga_in.hcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.rgb    <= (active && in_cols && in_rows) ? PLAYER_COLOR : vga_in.rgb;
            vblnk_d        <= vga_in.vblnk;
            if (tick) begin
                // The tick sits in blanking, so no wall pixel is lost here.
                {blk_u, blk_d, blk_l, blk_r} <= 4'b0;
                pending_dir <= req_dir;
                if (go_dir != D_NONE) begin
                    cur_dir  <= go_dir;
                    player_x <= next_x;
                    player_y <= next_y;
                    state    <= MOVE;
                end else begin
                    state    <= IDLE;
                end
            end else begin
                blk_u <= blk_u | hit_u;
                blk_d <= blk_d | hit_d;
                blk_l <= blk_l | hit_l;
                blk_r <= blk_r | hit_r;
                if (req_dir != D_NONE) pending_dir <= req_dir;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_player.sv
// tb_draw_player: short synthetic frames (a few pixels then a vblnk edge)
// drive the sprite; vga_out is checked through a scoreboard queue.
`default_nettype none

module tb_draw_player;
    import vga_pkg::*;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } out_t;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dir_req;
    logic [10:0] player_x, player_y;
    logic        moving;
    int          total = 0;
    int          bad = 0;
    out_t        sb[$];
    int          ex;

    vga_if vin();
    vga_if vout();

    draw_player dut (
        .clk     (clk),
        .rst     (rst),
        .vga_in  (vin),
        .vga_out (vout),
        .dir_req (dir_req),
        .player_x(player_x),
        .player_y(player_y),
        .moving  (moving)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic [11:0] rgb, input logic [3:0] dr,
                         input logic [11:0] exp_rgb);
        out_t e, got;
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[0];
        vin.vsync  = v[1];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        dir_req    = dr;
        if (rst) e = '0;
        else     e = '{h, v, h[0], v[1], hb, vb, exp_rgb};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = '{vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL vga_out: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL vga_out in=(%0d,%0d): got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                         h, v, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.rgb,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
            end
        end
    endtask

    task automatic check_pos(input string name, input int x, input int y, input logic m);
        total++;
        if (player_x !== 11'(x) || player_y !== 11'(y) || moving !== m) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d moving=%b, want x=%0d y=%0d moving=%b",
                     name, player_x, player_y, moving, x, y, m);
        end
    endtask

    // One frame: a single active pixel (optionally a blue wall pixel) then the vblnk edge.
    task automatic frame(input logic [3:0] dr, input logic blue, input logic [10:0] bh,
                         input logic [10:0] bv, input string name, input int x, input int y,
                         input logic m);
        if (blue) drive(bh, bv, 1'b0, 1'b0, BLUE, dr, BLUE);
        else      drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, dr, 12'h000);
        drive(11'd0, 11'd0, 1'b1, 1'b1, 12'h000, 4'b0, 12'h000);
        check_pos(name, x, y, m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(11'd510, 11'd380, 1'b0, 1'b0, 12'h123, 4'b0, 12'h000);
        rst = 1'b0;
        check_pos("reset", 504, 376, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{11'd503, 11'd376, 1'b0, 12'h000, 12'h000};
        vecs[1] = '{11'd504, 11'd376, 1'b0, 12'h000, 12'hFF0};
        vecs[2] = '{11'd519, 11'd391, 1'b0, 12'h000, 12'hFF0};
        vecs[3] = '{11'd520, 11'd391, 1'b0, 12'h000, 12'h000};
        vecs[4] = '{11'd519, 11'd392, 1'b0, 12'h000, 12'h000};
        vecs[5] = '{11'd504, 11'd375, 1'b0, 12'h000, 12'h000};
        vecs[6] = '{11'd512, 11'd384, 1'b1, 12'h0AB, 12'h0AB};
        vecs[7] = '{11'd512, 11'd384, 1'b0, 12'h0AB, 12'hFF0};
        vecs[8] = '{11'd700, 11'd100, 1'b0, 12'h0F0, 12'h0F0};

        rst = 1'b1;
        dir_req = 4'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, idle frames, then sprite overlay table
        do_reset();
        for (int i = 0; i < 3; i++) frame(4'b0, 1'b0, 11'd0, 11'd0, "idle", 504, 376, 1'b0);
        for (int i = 0; i < 9; i++)
            drive(vecs[i].h, vecs[i].v, vecs[i].hb, 1'b0, vecs[i].rgb, 4'b0, vecs[i].exp_rgb);

        // Right pulse, run to the right screen edge
        frame(4'b0001, 1'b0, 11'd0, 11'd0, "right1", 506, 376, 1'b1);
        ex = 506;
        while (ex < 1008) begin
            ex += 2;
            frame(4'b0, 1'b0, 11'd0, 11'd0, "right_run", ex, 376, 1'b1);
        end
        frame(4'b0, 1'b0, 11'd0, 11'd0, "right_edge", 1008, 376, 1'b0);
        frame(4'b0001, 1'b0, 11'd0, 11'd0, "right_edge_req", 1008, 376, 1'b0);

        // Blue wall to the right of a right-moving sprite
        do_reset();
        frame(4'b0010, 1'b0, 11'd0, 11'd0, "left1", 502, 376, 1'b1);
        frame(4'b0001, 1'b0, 11'd0, 11'd0, "back_right", 504, 376, 1'b1);
        frame(4'b0, 1'b1, 11'd520, 11'd380, "wall_right", 504, 376, 1'b0);
        frame(4'b0001, 1'b1, 11'd520, 11'd380, "wall_right_req", 504, 376, 1'b0);

        // Up beats right
        do_reset();
        frame(4'b1001, 1'b0, 11'd0, 11'd0, "up_prio", 504, 374, 1'b1);
        frame(4'b0, 1'b0, 11'd0, 11'd0, "up_run1", 504, 372, 1'b1);
        frame(4'b0, 1'b0, 11'd0, 11'd0, "up_run2", 504, 370, 1'b1);

        // Up request blocked by a wall keeps moving right, later turns up
        do_reset();
        frame(4'b0001, 1'b0, 11'd0, 11'd0, "r_then", 506, 376, 1'b1);
        frame(4'b1000, 1'b1, 11'd510, 11'd375, "up_blocked", 508, 376, 1'b1);
        frame(4'b1000, 1'b0, 11'd0, 11'd0, "up_turn", 508, 374, 1'b1);
        frame(4'b0, 1'b0, 11'd0, 11'd0, "up_cont", 508, 372, 1'b1);

        // One-cycle reset mid-frame while moving
        drive(11'd100, 11'd100, 1'b0, 1'b0, 12'h321, 4'b0, 12'h321);
        do_reset();
        frame(4'b0, 1'b0, 11'd0, 11'd0, "post_reset_idle", 504, 376, 1'b0);

        // Wall seen before a reset must not block the first move afterwards
        drive(11'd520, 11'd380, 1'b0, 1'b0, BLUE, 4'b0, BLUE);
        do_reset();
        frame(4'b0001, 1'b0, 11'd0, 11'd0, "stale_flag", 506, 376, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_player.md
DRAW_PLAYER -- requirements
Module: draw_player

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SIZE, 16, sprite edge in pixels.
- STEP, 2, pixels moved per frame.
- START_X, 504, sprite left column after reset.
- START_Y, 376, sprite top row after reset.
- PLAYER_COLOR, 12'hF_F_0, sprite colour.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- vga_in, vga_if.in, -, timing plus rgb from the background stage.
- vga_out, vga_if.out, -, timing plus rgb with the sprite overlaid.
- dir_req, input, 4, requests as bits [3]=up, [2]=down, [1]=left, [0]=right.
- player_x, output, 11, registered sprite left column.
- player_y, output, 11, registered sprite top row.
- moving, output, 1, high while the state is MOVE.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 Wall colour SHALL be BLUE from vga_pkg; HOR_PIXELS and VER_PIXELS SHALL also come from vga_pkg.

Function
REQ-005 Latency SHALL be 1 cycle: all vga_out timing fields equal vga_in delayed by one clk.
REQ-006 Overlay: vga_out.rgb SHALL be PLAYER_COLOR when no blanking AND player_x<=hcount<player_x+SIZE AND player_y<=vcount<player_y+SIZE; otherwise it SHALL be vga_in.rgb.
REQ-007 Frame tick SHALL be asserted for one cycle on each rising edge of vga_in.vblnk, detected against a registered copy of vga_in.vblnk.
REQ-008 Request latch: any cycle with dir_req!=0 SHALL load pending_dir. Priority is up>down>left>right. pending_dir SHALL be cleared on the cycle after it is consumed at a tick.
REQ-009 Collision flags blk_u, blk_d, blk_l, blk_r SHALL be set during active video when vga_in.rgb==BLUE inside the corresponding strip:
- up: columns [x, x+SIZE-1], rows [y-STEP, y-1].
- down: columns [x, x+SIZE-1], rows [y+SIZE, y+SIZE+STEP-1].
- left: rows [y, y+SIZE-1], columns [x-STEP, x-1].
- right: rows [y, y+SIZE-1], columns [x+SIZE, x+SIZE+STEP-1].
REQ-010 A direction SHALL also count as blocked when the move would leave the screen:
- up: y<STEP.
- left: x<STEP.
- down: y+SIZE+STEP>VER_PIXELS.
- right: x+SIZE+STEP>HOR_PIXELS.
REQ-011 The flags SHALL be consumed at the tick and cleared on the following cycle; pixels arriving on the tick cycle cannot occur, because the tick lies inside blanking.
REQ-012 States: IDLE and MOVE. cur_dir holds the current direction, or none.
REQ-013 At a tick with pending_dir valid and not blocked: cur_dir SHALL become pending_dir, the position SHALL step STEP in that direction, and the state SHALL become MOVE.
REQ-014 At a tick with pending_dir valid but blocked: cur_dir SHALL be kept. If cur_dir is not blocked the block SHALL step in cur_dir and go to MOVE; otherwise it SHALL go to IDLE.
REQ-015 At a tick with no pending_dir: the block SHALL step in cur_dir if it is not blocked and stay in or enter MOVE; otherwise it SHALL not move and SHALL go to IDLE.
REQ-016 Outside ticks, player_x and player_y SHALL stay constant, so the sprite never tears within a frame.
REQ-017 All position arithmetic SHALL be 11-bit unsigned; the REQ-010 guards ensure no wrap-around is ever produced.

Reset
REQ-018 While rst=1 the block SHALL set the following values:
- All vga_out fields: 0.
- player_x: START_X.
- player_y: START_Y.
- moving: 0.
- State: IDLE.
- cur_dir: none.
- pending_dir: none.
- Collision flags and registered vblnk: 0.
REQ-019 Reset asserted mid-frame SHALL take effect on the next clk edge. The first tick after reset release SHALL use only flags gathered since the release.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, black background, no dir_req for 3 frames -> player_x=504, player_y=376, moving=0; sprite pixels read 12'hFF0 one cycle after hcount 504..519, vcount 376..391.
- One-cycle pulse dir_req=4'b0001 in frame 0, black background -> at the next tick x=506, moving=1; x grows by 2 each frame until x=1008 (HOR_PIXELS 1024), after which it stays there and moving=0.
- BLUE pixel injected at hcount=520, vcount=380 with the sprite at x=504 moving right -> at the tick x is unchanged and moving=0.
- dir_req=4'b1001 pulsed together -> up wins; y decrements by 2 per frame.
- Moving right, up requested while the up strip is blue -> keeps going right; once the wall ends, the next up request turns the sprite up.
- rst asserted for 1 cycle mid-frame while moving -> next cycle position is 504/376, vga_out is 0, moving=0.
